fetch_arbiter: RTL and testbench

- Instruction fetch unit with a prefetch queue, sitting upstream of the IF/ID pipeline register.
- Owns the single-ported unified memory and arbitrates it between instruction fetch and MEM-stage data accesses. Data accesses have priority.
- Fetched words go into a small FIFO and are offered to decode through a valid/ready handshake.
- A branch/jump redirect from MEM flushes the queue and restarts fetch.

---
 rtl/fetch_arbiter.sv | 145 ++++++++++++++
 tb/tb_fetch_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// rtl/fetch_arbiter.sv - instruction prefetch queue and unified-memory arbiter
module fetch_arbiter #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [2:0]        dmem_funct3,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  output logic [31:0]       fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               epoch_q, epoch_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        tag_pc_q, tag_pc_d;
  logic               tag_epoch_q, tag_epoch_d;
  logic [31:0]        fifo_inst_q [DEPTH];
  logic [31:0]        fifo_inst_d [DEPTH];
  logic [31:0]        fifo_pc_q [DEPTH];
  logic [31:0]        fifo_pc_d [DEPTH];

  logic               in_flight, fetch_room, issue_data, issue_fetch, push, pop;
  logic [CNT_W:0]     occupancy;

  // Issue arbitration: data wins unless a data access is already completing;
  // fetch only when every in-flight word is guaranteed a FIFO slot.
  // Nothing is issued while reset is asserted so all memory outputs read 0.
  assign in_flight   = (state_q == IFETCH);
  assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, in_flight};
  assign fetch_room  = (occupancy < (CNT_W + 1)'(DEPTH));
  assign issue_data  = rst && dmem_req && (state_q != DATA);
  assign issue_fetch = rst && !issue_data && fetch_room;

  // FSM next state and combinational memory port drive
  always_comb begin
    state_d    = IDLE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (issue_data) begin
      state_d    = DATA;
      mem_en     = 1'b1;
      mem_we     = dmem_we;
      mem_funct3 = dmem_funct3;
      mem_addr   = dmem_addr;
      mem_wdata  = dmem_wdata;
    end else if (issue_fetch) begin
      state_d    = IFETCH;
      mem_en     = 1'b1;
      mem_funct3 = 3'b010;
      mem_addr   = fetch_pc_q[ADDR_W-1:0];
    end
  end

  // FIFO, fetch pc and epoch bookkeeping; a stale-epoch or redirect-cycle word is dropped
  always_comb begin
    push        = in_flight && (tag_epoch_q == epoch_q) && !redirect;
    pop         = inst_valid && inst_ready && !redirect;
    count_d     = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    epoch_d     = epoch_q;
    fetch_pc_d  = issue_fetch ? fetch_pc_q + 32'd4 : fetch_pc_q;
    tag_pc_d    = issue_fetch ? fetch_pc_q : tag_pc_q;
    tag_epoch_d = issue_fetch ? epoch_q : tag_epoch_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (push) begin
      fifo_inst_d[wr_ptr_q] = mem_rdata;
      fifo_pc_d[wr_ptr_q]   = tag_pc_q;
    end
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      epoch_d    = ~epoch_q;
      fetch_pc_d = redirect_pc & ~32'h3;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      epoch_q     <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      tag_pc_q    <= '0;
      tag_epoch_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      epoch_q     <= epoch_d;
      fetch_pc_q  <= fetch_pc_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
  assign dmem_done  = (state_q == DATA);
  assign dmem_rdata = dmem_done ? mem_rdata : 32'h0;
  assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// tb/tb_fetch_arbiter.sv - scoreboard bench for fetch_arbiter
module tb_fetch_arbiter;
  localparam int ADDR_W = 9;

  logic              clk, rst, redirect;
  logic [31:0]       redirect_pc;
  logic              dmem_req, dmem_we;
  logic [2:0]        dmem_funct3;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata, dmem_rdata;
  logic              dmem_done, mem_en, mem_we;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              inst_valid, inst_ready;
  logic [31:0]       inst, inst_pc, fetch_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic [32:0] dq[$];
  ent_t        mon_e;
  logic [32:0] mon_d;
  logic [31:0] mem [0:127];
  int          n_vec = 0;
  int          n_err = 0;
  bit          stored = 1'b0;

  fetch_arbiter #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_funct3(dmem_funct3),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_done(dmem_done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_pc(fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported synchronous memory: read data valid the cycle after issue
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[ADDR_W-1:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    if (pc == 32'h40) return 32'hDEADBEEF;
    if (stored && pc == 32'h10) return 32'hA5A5A5A5;
    return pc + 32'h13;
  endfunction

  task automatic push_seq(input logic [31:0] start);
    for (int i = 0; i < 48; i++) begin
      ent_t e;
      e.pc   = start + 32'(4 * i);
      e.inst = exp_inst(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset one cycle, check reset outputs, release at the start of cycle 0
  task automatic do_reset(input logic rdy);
    rst = 1'b0; redirect = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; inst_ready = rdy;
    @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_dmem_done", {31'b0, dmem_done}, 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    step();
    exp_q.delete();
    dq.delete();
    push_seq(32'h0);
    rst = 1'b1;
  endtask

  task automatic chk_start(input string nm);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk(nm, {31'b0, inst_valid}, (c >= 2) ? 32'd1 : 32'd0);
      if (c == 2) chk({nm, "_pc"}, inst_pc, 32'h0);
      step();
    end
  endtask

  // Monitor: every accepted instruction and every data completion is matched against the scoreboard
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL pop_unexpected: got pc %h, required no pop", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", inst_pc, mon_e.pc);
        chk("pop_inst", inst, mon_e.inst);
      end
    end
    if (dmem_done) begin
      if (dq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done_unexpected: got dmem_done 1, required 0");
      end else begin
        mon_d = dq.pop_front();
        if (mon_d[32]) chk("done_rdata", dmem_rdata, mon_d[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; dmem_req = 1'b0; dmem_we = 1'b0;
    dmem_funct3 = '0; dmem_addr = '0; dmem_wdata = '0; inst_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4) + 32'h13;
    mem[16] = 32'hDEADBEEF;

    // Streaming from reset: first valid at cycle 2, no gaps afterwards
    do_reset(1'b1);
    chk_start("t1_valid");
    for (int c = 4; c < 10; c++) begin
      @(negedge clk);
      chk("t1_stream", {31'b0, inst_valid}, 1);
      step();
    end

    // Decode stalled: queue saturates, then drains in order
    do_reset(1'b0);
    repeat (7) step();
    @(negedge clk);
    chk("t2_full_valid", {31'b0, inst_valid}, 1);
    chk("t2_full_mem_en", {31'b0, mem_en}, 0);
    chk("t2_fetch_pc", fetch_pc, 32'h10);
    step();
    inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_drain_valid", {31'b0, inst_valid}, 1);
      step();
    end

    // Data load preempts fetch during streaming
    do_reset(1'b1);
    repeat (6) step();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_funct3 = 3'b100; dmem_addr = 9'h040;
    dq.push_back({1'b1, 32'hDEADBEEF});
    @(negedge clk);
    chk("t3_mem_en", {31'b0, mem_en}, 1);
    chk("t3_mem_addr", {23'b0, mem_addr}, 32'h40);
    chk("t3_mem_we", {31'b0, mem_we}, 0);
    chk("t3_mem_funct3", {29'b0, mem_funct3}, 32'h4);
    chk("t3_done_early", {31'b0, dmem_done}, 0);
    step();
    @(negedge clk);
    chk("t3_done", {31'b0, dmem_done}, 1);
    chk("t3_rdata", dmem_rdata, 32'hDEADBEEF);
    step();
    dmem_req = 1'b0;
    @(negedge clk);
    chk("t3_done_once", {31'b0, dmem_done}, 0);
    repeat (20) step();
    chk("t3_dq_drained", dq.size(), 0);

    // Redirect with three queued entries and a fetch in flight
    do_reset(1'b0);
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    chk("t4_pre_valid", {31'b0, inst_valid}, 1);
    chk("t4_pre_mem_en", {31'b0, mem_en}, 0);
    step();
    redirect = 1'b0; inst_ready = 1'b1;
    exp_q.delete();
    push_seq(32'h100);
    @(negedge clk);
    chk("t4_flush_valid", {31'b0, inst_valid}, 0);
    chk("t4_fetch_addr", {23'b0, mem_addr}, 32'h100);
    step();
    @(negedge clk);
    chk("t4_gap_valid", {31'b0, inst_valid}, 0);
    step();
    @(negedge clk);
    chk("t4_first_valid", {31'b0, inst_valid}, 1);
    chk("t4_first_pc", inst_pc, 32'h100);
    repeat (10) step();

    // Store, then redirect onto the stored word
    do_reset(1'b0);
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_funct3 = 3'b010; dmem_addr = 9'h010;
    dmem_wdata = 32'hA5A5A5A5;
    dq.push_back({1'b0, 32'h0});
    @(negedge clk);
    chk("t5_mem_we", {31'b0, mem_we}, 1);
    chk("t5_mem_addr", {23'b0, mem_addr}, 32'h10);
    chk("t5_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    step();
    @(negedge clk);
    chk("t5_done", {31'b0, dmem_done}, 1);
    step();
    dmem_req = 1'b0; dmem_we = 1'b0; stored = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0; inst_ready = 1'b1;
    exp_q.delete();
    push_seq(32'h10);
    @(negedge clk);
    chk("t5_valid_c1", {31'b0, inst_valid}, 0);
    step();
    @(negedge clk);
    chk("t5_valid_c2", {31'b0, inst_valid}, 0);
    step();
    @(negedge clk);
    chk("t5_valid_c3", {31'b0, inst_valid}, 1);
    chk("t5_inst", inst, 32'hA5A5A5A5);
    chk("t5_inst_pc", inst_pc, 32'h10);
    repeat (6) step();

    // Reset while a data access is in flight
    do_reset(1'b1);
    repeat (5) step();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_funct3 = 3'b010; dmem_addr = 9'h040;
    @(negedge clk);
    chk("t6_mem_en", {31'b0, mem_en}, 1);
    chk("t6_mem_addr", {23'b0, mem_addr}, 32'h40);
    rst = 1'b0; dmem_req = 1'b0;
    step();
    @(negedge clk);
    chk("t6_no_done", {31'b0, dmem_done}, 0);
    chk("t6_mem_en_rst", {31'b0, mem_en}, 0);
    step();
    do_reset(1'b1);
    chk_start("t6_valid");
    repeat (4) step();
    chk("t6_dq_empty", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
